// File: rtl/wt_dcache_mem_responder.sv
// Memory-side responder for the write-through L1 dcache miss/store port: one request at a time,
// carried out on a req/gnt/rvalid SRAM port, answered with a tagged return.
module wt_dcache_mem_responder #(
   parameter int unsigned PADDR_W    = 56,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned LINE_W     = 128,
   parameter int unsigned TID_W      = 2,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_store_i,
   input  logic                  req_nc_i,
   input  logic [1:0]            req_size_i,
   input  logic [PADDR_W-1:0]    req_paddr_i,
   input  logic [DATA_W-1:0]     req_data_i,
   input  logic [TID_W-1:0]      req_tid_i,
   output logic                  rtrn_valid_o,
   input  logic                  rtrn_ready_i,
   output logic                  rtrn_store_o,
   output logic [TID_W-1:0]      rtrn_tid_o,
   output logic [LINE_W-1:0]     rtrn_data_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic                  mem_we_o,
   output logic [PADDR_W-1:0]    mem_addr_o,
   output logic [DATA_W/8-1:0]   mem_be_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_W-1:0]     mem_rdata_i
);

   localparam int unsigned Beats   = LINE_W / DATA_W;
   localparam int unsigned BeW     = DATA_W / 8;
   localparam int unsigned WordOff = $clog2(BeW);
   localparam int unsigned CntW    = (Beats > 1) ? $clog2(Beats) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e              state_q;
   logic [CntW-1:0]     beat_q;
   logic                store_q, nc_q;
   logic [TID_W-1:0]    tid_q;
   logic [PADDR_W-1:0]  paddr_q;
   logic [LINE_W-1:0]   line_q;
   logic                req_ready_q, mem_req_q, mem_we_q, rtrn_valid_q;
   logic [PADDR_W-1:0]  mem_addr_q;
   logic [BeW-1:0]      mem_be_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   function automatic logic [DATA_W-1:0] lane_swap(input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] r;
      for (int unsigned i = 0; i < BeW; i++) r[8*i +: 8] = d[8*(BeW-1-i) +: 8];
      return BIG_ENDIAN ? r : d;
   endfunction

   function automatic logic [BeW-1:0] be_swap(input logic [BeW-1:0] b);
      logic [BeW-1:0] r;
      for (int unsigned i = 0; i < BeW; i++) r[i] = b[BeW-1-i];
      return BIG_ENDIAN ? r : b;
   endfunction

   // Line loads walk the line from its base; everything else is one word-aligned beat.
   function automatic logic [PADDR_W-1:0] beat_addr(input logic [PADDR_W-1:0] pa,
                                                    input logic line, input logic [CntW-1:0] beat);
      logic [PADDR_W-1:0] word_base, line_base;
      word_base = pa & ~PADDR_W'(BeW - 1);
      line_base = pa & ~PADDR_W'(LINE_W / 8 - 1);
      return line ? line_base + (PADDR_W'(beat) << WordOff) : word_base;
   endfunction

   // Lanes past the end of the word are dropped, so misaligned stores clip.
   function automatic logic [BeW-1:0] store_be(input logic [1:0] size,
                                               input logic [PADDR_W-1:0] pa);
      logic [BeW-1:0] be;
      int unsigned    off, len;
      off = 32'(pa & PADDR_W'(BeW - 1));
      len = 32'd1 << size;
      for (int unsigned i = 0; i < BeW; i++) be[i] = (i >= off) && (i < off + len);
      return be;
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         beat_q       <= '0;
         store_q      <= 1'b0;
         nc_q         <= 1'b0;
         tid_q        <= '0;
         paddr_q      <= '0;
         line_q       <= '0;
         req_ready_q  <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         rtrn_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  state_q     <= StReq;
                  beat_q      <= '0;
                  store_q     <= req_store_i;
                  nc_q        <= req_nc_i;
                  tid_q       <= req_tid_i;
                  paddr_q     <= req_paddr_i;
                  line_q      <= '0;
                  req_ready_q <= 1'b0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= req_store_i;
                  mem_addr_q  <= beat_addr(req_paddr_i, !req_store_i && !req_nc_i, '0);
                  mem_be_q    <= req_store_i ? be_swap(store_be(req_size_i, req_paddr_i)) : '1;
                  mem_wdata_q <= req_store_i ? lane_swap(req_data_i) : '0;
               end
            end
            StReq: begin
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  if (store_q) begin
                     state_q      <= StResp;
                     rtrn_valid_q <= 1'b1;
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               if (mem_rvalid_i) begin
                  if (nc_q) line_q <= {Beats{lane_swap(mem_rdata_i)}};
                  else      line_q[beat_q*DATA_W +: DATA_W] <= lane_swap(mem_rdata_i);
                  if (!nc_q && beat_q != CntW'(Beats - 1)) begin
                     beat_q     <= beat_q + 1'b1;
                     mem_addr_q <= beat_addr(paddr_q, 1'b1, beat_q + 1'b1);
                     mem_req_q  <= 1'b1;
                     state_q    <= StReq;
                  end else begin
                     state_q      <= StResp;
                     rtrn_valid_q <= 1'b1;
                  end
               end
            end
            StResp: begin
               if (rtrn_ready_i) begin
                  state_q      <= StIdle;
                  rtrn_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready_o  = req_ready_q;
   assign rtrn_valid_o = rtrn_valid_q;
   assign rtrn_store_o = store_q;
   assign rtrn_tid_o   = tid_q;
   assign rtrn_data_o  = line_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_be_o     = mem_be_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule
